// File: rtl/ecc_scrub_controller.sv
// ECC scrubber: sweeps every memory word, rewrites single-bit-corrected codewords
// and counts corrected and uncorrectable words.

module one_hot_encoder #(
  parameter int in_bit_width  = 7,
  parameter int out_bit_width = 128
) (
  input  logic [in_bit_width-1:0]  in_i,
  output logic [out_bit_width-1:0] out_o
);

  function automatic logic [out_bit_width-1:0] decode_f(input logic [in_bit_width-1:0] sel);
    logic [out_bit_width-1:0] res;
    res = out_bit_width'(1'b1) << sel;
    return res;
  endfunction

  assign out_o = decode_f(in_i);

endmodule

module ecc_scrub_controller #(
  parameter int syn_width  = 7,
  parameter int cw_width   = 32'd1 << syn_width,
  parameter int addr_width = 10,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [cw_width-1:0]   mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [cw_width-1:0]   mem_rdata,
  input  logic [syn_width-1:0]  syn_in,
  input  logic                  ded_in,
  output logic [cnt_width-1:0]  corr_cnt,
  output logic [cnt_width-1:0]  unc_cnt,
  output logic [addr_width-1:0] unc_addr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [cw_width-1:0]   wdata_q, wdata_d;
  logic [cnt_width-1:0]  corr_q, corr_d;
  logic [cnt_width-1:0]  unc_q, unc_d;
  logic [addr_width-1:0] unc_addr_q, unc_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [cw_width-1:0]   flip_mask;

  function automatic logic [cnt_width-1:0] sat_inc_f(input logic [cnt_width-1:0] v);
    if (v == {cnt_width{1'b1}}) begin
      return v;
    end else begin
      return v + cnt_width'(1'b1);
    end
  endfunction

  one_hot_encoder #(
    .in_bit_width (syn_width),
    .out_bit_width(cw_width)
  ) u_flip_mask (
    .in_i (syn_in),
    .out_o(flip_mask)
  );

  // Next-state, address, capture and counter update logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    corr_d     = corr_q;
    unc_d      = unc_q;
    unc_addr_d = unc_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_REQ;
          addr_d  = '0;
          corr_d  = '0;
          unc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_gnt) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          // A double error overrides whatever the syndrome says.
          if (ded_in) begin
            unc_d      = sat_inc_f(unc_q);
            unc_addr_d = addr_q;
            state_d    = NEXT;
          end else if (syn_in != {syn_width{1'b0}}) begin
            corr_d  = sat_inc_f(corr_q);
            wdata_d = mem_rdata ^ flip_mask;
            state_d = WR_REQ;
          end else begin
            state_d = NEXT;
          end
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (mem_gnt) begin
          state_d = NEXT;
        end else begin
          state_d = WR_REQ;
        end
      end
      NEXT: begin
        if (addr_q == {addr_width{1'b1}}) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + addr_width'(1'b1);
          state_d = RD_REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flags decoded from the upcoming state so they leave flops.
  always_comb begin
    busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
             (state_d == WR_REQ) || (state_d == NEXT);
    done_d = (state_d == DONE);
    req_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
    we_d   = (state_d == WR_REQ);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      corr_q     <= '0;
      unc_q      <= '0;
      unc_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      corr_q     <= corr_d;
      unc_q      <= unc_d;
      unc_addr_q <= unc_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
      we_q       <= we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign corr_cnt  = corr_q;
  assign unc_cnt   = unc_q;
  assign unc_addr  = unc_addr_q;

endmodule

// File: tb/tb_ecc_scrub_controller.sv
// Bench for ecc_scrub_controller: a memory responder plus a per-sweep reference
// model of expected accesses, counters and sweep length.

module tb_ecc_scrub_controller;

  localparam int SW   = 7;
  localparam int CW   = 128;
  localparam int AW   = 2;
  localparam int NW   = 2;
  localparam int NWRD = 1 << AW;
  localparam int CMAX = (1 << NW) - 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [CW-1:0] mem_rdata = '0;
  logic [SW-1:0] syn_in = '0;
  logic          ded_in = 1'b0;
  logic [NW-1:0] corr_cnt, unc_cnt;
  logic [AW-1:0] unc_addr;

  ecc_scrub_controller #(
    .syn_width(SW), .cw_width(CW), .addr_width(AW), .cnt_width(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .syn_in(syn_in), .ded_in(ded_in), .corr_cnt(corr_cnt), .unc_cnt(unc_cnt),
    .unc_addr(unc_addr)
  );

  always #5 clk = ~clk;

  // memory contents and error injection per word
  logic [CW-1:0] m_data [NWRD];
  logic [SW-1:0] m_syn  [NWRD];
  logic          m_ded  [NWRD];

  int   stall_cfg = 0;
  int   lat_cfg = 1;
  int   stab_err = 0;
  int   ovl_err = 0;
  acc_t log_q[$];
  acc_t exp_q[$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   e_corr, e_unc, e_unc_addr = 0, e_cycles;

  logic          req_pend = 1'b0;
  int            stall_left = 0;
  acc_t          held;
  logic          rv_pend = 1'b0;
  int            rv_cnt = 0;
  logic [AW-1:0] rd_addr = '0;

  function automatic logic [CW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory responder: grants after stall_cfg cycles, returns read data lat_cfg cycles later.
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = rand128();
    syn_in     = SW'($urandom);
    ded_in     = 1'($urandom);
    if (!rst_n) begin
      req_pend = 1'b0;
      rv_pend  = 1'b0;
    end else begin
      if (rv_pend) begin
        if (rv_cnt <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = m_data[rd_addr];
          syn_in     = m_syn[rd_addr];
          ded_in     = m_ded[rd_addr];
          rv_pend    = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      if (mem_req) begin
        if (rv_pend) ovl_err++;
        if (!req_pend) begin
          req_pend   = 1'b1;
          held       = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
          stall_left = stall_cfg;
        end else if ({mem_we, mem_addr, mem_wdata} !== held) begin
          stab_err++;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_gnt  = 1'b1;
          req_pend = 1'b0;
          log_q.push_back(held);
          if (!held.we) begin
            rv_pend = 1'b1;
            rv_cnt  = lat_cfg;
            rd_addr = held.addr;
          end
        end
      end else if (req_pend) begin
        stab_err++;
      end
    end
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the words in order, applying the scrub rules.
  task automatic build_expect();
    acc_t          a;
    logic [CW-1:0] w;
    exp_q.delete();
    e_corr   = 0;
    e_unc    = 0;
    e_cycles = 0;
    for (int i = 0; i < NWRD; i++) begin
      a = '{we: 1'b0, addr: AW'(i), wdata: '0};
      exp_q.push_back(a);
      e_cycles += (1 + stall_cfg) + lat_cfg + 1;
      if (m_ded[i]) begin
        if (e_unc < CMAX) e_unc++;
        e_unc_addr = i;
      end else if (m_syn[i] != 0) begin
        w = m_data[i];
        w[m_syn[i]] = ~w[m_syn[i]];
        a = '{we: 1'b1, addr: AW'(i), wdata: w};
        exp_q.push_back(a);
        if (e_corr < CMAX) e_corr++;
        e_cycles += 1 + stall_cfg;
      end
    end
  endtask

  task automatic set_clean();
    for (int i = 0; i < NWRD; i++) begin
      m_data[i] = rand128();
      m_syn[i]  = '0;
      m_ded[i]  = 1'b0;
    end
  endtask

  task automatic run_sweep(input string name, input int poke);
    int cyc;
    log_q.delete();
    stab_err = 0;
    ovl_err  = 0;
    build_expect();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({name, ".busy_rise"}, CW'(busy), CW'(1));
    cyc = 0;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    chk({name, ".done"}, CW'(done), CW'(1));
    chk({name, ".busy_at_done"}, CW'(busy), CW'(0));
    chk({name, ".cycles"}, CW'(cyc), CW'(e_cycles));
    chk({name, ".n_access"}, CW'(log_q.size()), CW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s.we%0d", name, i), CW'(log_q[i].we), CW'(exp_q[i].we));
      chk($sformatf("%s.addr%0d", name, i), CW'(log_q[i].addr), CW'(exp_q[i].addr));
      if (exp_q[i].we) chk($sformatf("%s.wdata%0d", name, i), log_q[i].wdata, exp_q[i].wdata);
    end
    chk({name, ".stable"}, CW'(stab_err), CW'(0));
    chk({name, ".overlap"}, CW'(ovl_err), CW'(0));
    repeat (3) @(negedge clk);
    chk({name, ".done_pulse"}, CW'(done), CW'(0));
    chk({name, ".corr_cnt"}, CW'(corr_cnt), CW'(e_corr));
    chk({name, ".unc_cnt"}, CW'(unc_cnt), CW'(e_unc));
    chk({name, ".unc_addr"}, CW'(unc_addr), CW'(e_unc_addr));
  endtask

  initial begin
    int cyc;
    logic bad;
    set_clean();
    repeat (2) @(negedge clk);
    chk("rst.outs", CW'({busy, done, mem_req, mem_we, mem_addr, corr_cnt, unc_cnt, unc_addr}), CW'(0));
    chk("rst.wdata", mem_wdata, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_clean();
    run_sweep("clean", 0);

    set_clean();
    m_syn[2] = 7'd5;
    run_sweep("single", 0);

    set_clean();
    m_ded[1] = 1'b1;
    m_syn[1] = 7'd3;
    run_sweep("double", 0);

    set_clean();
    m_syn[0] = 7'd77;
    stall_cfg = 5;
    run_sweep("stall", 0);

    stall_cfg = 0;
    for (int i = 0; i < NWRD; i++) begin
      m_data[i] = rand128();
      m_syn[i]  = 7'd1;
      m_ded[i]  = 1'b0;
    end
    run_sweep("saturate", 4);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NWRD; i++) begin
        int kind;
        kind      = $urandom_range(0, 2);
        m_data[i] = rand128();
        m_syn[i]  = (kind == 0) ? SW'(0) : SW'($urandom_range(1, CW - 1));
        m_ded[i]  = (kind == 2);
      end
      stall_cfg = $urandom_range(0, 2);
      lat_cfg   = $urandom_range(1, 3);
      run_sweep($sformatf("rand%0d", r), 0);
    end

    // reset while a write waits for its grant
    stall_cfg = 10;
    lat_cfg   = 1;
    set_clean();
    m_syn[0] = 7'd9;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstwr.reached", CW'(mem_req && mem_we), CW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rstwr.outs", CW'({busy, done, mem_req, mem_we, mem_addr, corr_cnt, unc_cnt, unc_addr}), CW'(0));
    chk("rstwr.wdata", mem_wdata, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e_unc_addr = 0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || busy) bad = 1'b1;
    end
    chk("rstwr.quiet", CW'(bad), CW'(0));
    stall_cfg = 0;
    set_clean();
    run_sweep("after_rst", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
